// File: rtl/memory_utils_pkg.sv
// Shared memory-side types: a PDP-8 machine word.
package memory_utils_pkg;
    typedef logic [11:0] word;
endpackage

// File: rtl/micro_ops_pkg.sv
// PDP-8 operate (OPR) micro-op mask layout, field encodings and encoder state.
package micro_ops_pkg;
    import memory_utils_pkg::word;

    typedef word         opr_word_t;
    typedef logic [17:0] micro_op_mask_t;

    localparam int MAX_SEQ = 6;

    localparam int B_CLA = 0;
    localparam int B_CLL = 1;
    localparam int B_CMA = 2;
    localparam int B_CML = 3;
    localparam int B_IAC = 4;
    localparam int B_RAR = 5;
    localparam int B_RAL = 6;
    localparam int B_RTR = 7;
    localparam int B_RTL = 8;
    localparam int B_BSW = 9;
    localparam int B_SMA = 10;
    localparam int B_SZA = 11;
    localparam int B_SNL = 12;
    localparam int B_SPA = 13;
    localparam int B_SNA = 14;
    localparam int B_SZL = 15;
    localparam int B_SKP = 16;
    localparam int B_HLT = 17;

    localparam opr_word_t OPR_BASE    = 12'o7000;
    localparam opr_word_t G2_BASE     = 12'o0400;
    localparam opr_word_t F_CLA       = 12'o0200;
    localparam opr_word_t F_CLL       = 12'o0100;
    localparam opr_word_t F_CMA       = 12'o0040;
    localparam opr_word_t F_CML       = 12'o0020;
    localparam opr_word_t F_IAC       = 12'o0001;
    localparam opr_word_t F_SKP_MINUS = 12'o0100;
    localparam opr_word_t F_SKP_ZERO  = 12'o0040;
    localparam opr_word_t F_SKP_LINK  = 12'o0020;
    localparam opr_word_t F_AND_SENSE = 12'o0010;
    localparam opr_word_t F_HLT       = 12'o0002;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUILD = 2'd1,
        S_EMIT  = 2'd2,
        S_ERR   = 2'd3
    } state_e;

    // Rotate field, indexed in priority order RAR, RAL, RTR, RTL, BSW.
    function automatic opr_word_t rot_code(input int i);
        case (i)
            0:       rot_code = 12'o0010;
            1:       rot_code = 12'o0004;
            2:       rot_code = 12'o0012;
            3:       rot_code = 12'o0006;
            default: rot_code = 12'o0002;
        endcase
    endfunction

    function automatic logic or_class(input micro_op_mask_t m);
        or_class = m[B_SMA] | m[B_SZA] | m[B_SNL];
    endfunction

    function automatic logic and_class(input micro_op_mask_t m);
        and_class = m[B_SPA] | m[B_SNA] | m[B_SZL] | m[B_SKP];
    endfunction
endpackage

// File: rtl/opr_sequence_builder.sv
// Combinational expansion of a micro-op mask into an ordered list of OPR words.
module opr_sequence_builder
    import micro_ops_pkg::*;
#(
    parameter bit FOLD_CLA     = 1'b0,
    parameter bit NOP_ON_EMPTY = 1'b1
) (
    input  micro_op_mask_t                 i_mask,
    output logic [MAX_SEQ-1:0][11:0]       o_words,
    output logic [2:0]                     o_count,
    output logic                           o_error
);
    logic      w_or_cls, w_and_cls, w_g2_any, w_fold, w_g1_emit, w_rot_seen;
    opr_word_t w_g1, w_g2;

    assign w_or_cls  = or_class(i_mask);
    assign w_and_cls = and_class(i_mask);
    assign w_g2_any  = w_or_cls | w_and_cls | i_mask[B_HLT];
    // CLA can ride in the group-2 word only when it is the sole group-1 op.
    assign w_fold    = FOLD_CLA && i_mask[B_CLA] && w_g2_any && !(|i_mask[B_BSW:B_CLL]);
    assign w_g1_emit = (|i_mask[B_BSW:B_CLA]) && !w_fold;
    assign o_error   = w_or_cls & w_and_cls;

    always_comb begin
        w_g2 = OPR_BASE | G2_BASE
             | (w_fold        ? F_CLA : '0)
             | (i_mask[B_HLT] ? F_HLT : '0);
        if (w_or_cls)
            w_g2 = w_g2 | (i_mask[B_SMA] ? F_SKP_MINUS : '0)
                        | (i_mask[B_SZA] ? F_SKP_ZERO  : '0)
                        | (i_mask[B_SNL] ? F_SKP_LINK  : '0);
        else if (w_and_cls)
            w_g2 = w_g2 | F_AND_SENSE
                        | (i_mask[B_SPA] ? F_SKP_MINUS : '0)
                        | (i_mask[B_SNA] ? F_SKP_ZERO  : '0)
                        | (i_mask[B_SZL] ? F_SKP_LINK  : '0);
    end

    always_comb begin
        o_words    = '0;
        o_count    = w_g1_emit ? 3'd1 : 3'd0;
        w_rot_seen = 1'b0;
        w_g1 = OPR_BASE
             | (i_mask[B_CLA] ? F_CLA : '0)
             | (i_mask[B_CLL] ? F_CLL : '0)
             | (i_mask[B_CMA] ? F_CMA : '0)
             | (i_mask[B_CML] ? F_CML : '0)
             | (i_mask[B_IAC] ? F_IAC : '0);
        // First rotate shares the group-1 word; the rest each need their own.
        for (int i = 0; i < 5; i++) begin
            if (i_mask[B_RAR + i]) begin
                if (!w_rot_seen) begin
                    w_rot_seen = 1'b1;
                    w_g1       = w_g1 | rot_code(i);
                end else begin
                    o_words[o_count] = OPR_BASE | rot_code(i);
                    o_count          = o_count + 3'd1;
                end
            end
        end
        if (w_g1_emit)
            o_words[0] = w_g1;
        if (w_g2_any) begin
            o_words[o_count] = w_g2;
            o_count          = o_count + 3'd1;
        end
        if (o_count == 3'd0 && NOP_ON_EMPTY) begin
            o_words[0] = OPR_BASE;
            o_count    = 3'd1;
        end
    end
endmodule

// File: rtl/micro_instruction_encoder.sv
// Accepts a micro-op request and streams the resulting OPR words over valid/ready.
module micro_instruction_encoder
    import micro_ops_pkg::*;
#(
    parameter bit FOLD_CLA     = 1'b0,
    parameter bit NOP_ON_EMPTY = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [17:0] req_ops,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_word,
    output logic [2:0]  out_index,
    output logic        out_last,
    output logic        err
);
    state_e                    r_state, w_next;
    micro_op_mask_t            r_mask, w_bld_mask;
    logic [MAX_SEQ-1:0][11:0]  r_words, w_words;
    logic [2:0]                r_count, w_count, r_idx;
    logic                      w_error, w_accept, w_fire, w_last;

    // In IDLE the builder looks at the live request so a conflict is caught at accept.
    assign w_bld_mask = (r_state == S_IDLE) ? req_ops : r_mask;

    opr_sequence_builder #(
        .FOLD_CLA     (FOLD_CLA),
        .NOP_ON_EMPTY (NOP_ON_EMPTY)
    ) u_builder (
        .i_mask  (w_bld_mask),
        .o_words (w_words),
        .o_count (w_count),
        .o_error (w_error)
    );

    assign req_ready = (r_state == S_IDLE) && rst_n;
    assign w_accept  = req_valid && req_ready;
    assign out_valid = (r_state == S_EMIT);
    assign w_fire    = out_valid && out_ready;
    assign w_last    = (r_idx == r_count - 3'd1);
    assign out_word  = out_valid ? r_words[r_idx] : 12'd0;
    assign out_index = r_idx;
    assign out_last  = out_valid && w_last;
    assign err       = (r_state == S_ERR);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = w_error ? S_ERR : S_BUILD;
            S_BUILD: w_next = (w_count != 3'd0) ? S_EMIT : S_IDLE;
            S_EMIT:  if (w_fire && w_last) w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mask  <= '0;
            r_words <= '0;
            r_count <= '0;
            r_idx   <= '0;
        end else begin
            if (w_accept)
                r_mask <= req_ops;
            if (r_state == S_BUILD) begin
                r_words <= w_words;
                r_count <= w_count;
                r_idx   <= '0;
            end else if (w_fire) begin
                r_idx <= w_last ? 3'd0 : r_idx + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_micro_instruction_encoder.sv
// Directed bench: instance a uses default parameters, instance b has FOLD_CLA=1, NOP_ON_EMPTY=0.
module tb_micro_instruction_encoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_valid_b = 1'b0;
    logic [17:0] req_ops = '0;
    logic        out_ready = 1'b1;

    logic        a_req_ready, a_out_valid, a_out_last, a_err;
    logic [11:0] a_out_word;
    logic [2:0]  a_out_index;
    logic        b_req_ready, b_out_valid, b_out_last, b_err;
    logic [11:0] b_out_word;
    logic [2:0]  b_out_index;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    micro_instruction_encoder #(.FOLD_CLA(1'b0), .NOP_ON_EMPTY(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(a_req_ready),
        .req_ops(req_ops), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_word(a_out_word), .out_index(a_out_index), .out_last(a_out_last), .err(a_err)
    );

    micro_instruction_encoder #(.FOLD_CLA(1'b1), .NOP_ON_EMPTY(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_ready(b_req_ready),
        .req_ops(req_ops), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_word(b_out_word), .out_index(b_out_index), .out_last(b_out_last), .err(b_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(input logic [17:0] m);
        req_ops   = m;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
    endtask

    task automatic send_b(input logic [17:0] m);
        req_ops     = m;
        req_valid_b = 1'b1;
        step();
        req_valid_b = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({a_req_ready, a_out_valid, a_out_word, a_out_index, a_out_last, a_err} !== 19'd0) begin
            errors++;
            $display("FAIL reset_a: got rdy=%0b v=%0b w=%o i=%0d l=%0b e=%0b, want all 0",
                     a_req_ready, a_out_valid, a_out_word, a_out_index, a_out_last, a_err);
        end
        checks++;
        if ({b_req_ready, b_out_valid, b_out_word, b_out_index, b_out_last, b_err} !== 19'd0) begin
            errors++;
            $display("FAIL reset_b: got rdy=%0b v=%0b w=%o, want all 0", b_req_ready, b_out_valid, b_out_word);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: got rdy_a=%0b rdy_b=%0b, want 1 1", a_req_ready, b_req_ready);
        end
    endtask

    task automatic test_single();
        logic [11:0] exp = 12'o7301;
        out_ready = 1'b1;
        send_a(18'h00013);
        checks++;
        if (a_out_valid !== 1'b0 || a_req_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_build: got v=%0b rdy=%0b, want 0 0", a_out_valid, a_req_ready);
        end
        step();
        checks++;
        if ({a_out_valid, a_out_word, a_out_index, a_out_last} !== {1'b1, exp, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL single_word: got v=%0b w=%o i=%0d l=%0b, want v=1 w=%o i=0 l=1",
                     a_out_valid, a_out_word, a_out_index, a_out_last, exp);
        end
        step();
        checks++;
        if (a_out_valid !== 1'b0 || a_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_done: got v=%0b rdy=%0b, want 0 1", a_out_valid, a_req_ready);
        end
    endtask

    task automatic test_two_words();
        logic [11:0] exp [2] = '{12'o7244, 12'o7012};
        send_a(18'h000C5);
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({a_out_valid, a_out_word, a_out_index, a_out_last} !== {1'b1, exp[i], 3'(i), 1'(i == 1)}) begin
                errors++;
                $display("FAIL two_words[%0d]: got v=%0b w=%o i=%0d l=%0b, want w=%o i=%0d l=%0b",
                         i, a_out_valid, a_out_word, a_out_index, a_out_last, exp[i], i, i == 1);
            end
        end
        step();
        checks++;
        if (a_out_valid !== 1'b0 || a_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL two_words_done: got v=%0b rdy=%0b, want 0 1", a_out_valid, a_req_ready);
        end
    endtask

    task automatic test_fold();
        logic [11:0] exp [2] = '{12'o7200, 12'o7462};
        logic [11:0] exp_b = 12'o7662;
        send_a(18'h21801);
        for (int i = 0; i < 2; i++) begin
            step();
            checks++;
            if ({a_out_valid, a_out_word, a_out_index, a_out_last} !== {1'b1, exp[i], 3'(i), 1'(i == 1)}) begin
                errors++;
                $display("FAIL nofold[%0d]: got v=%0b w=%o i=%0d l=%0b, want w=%o i=%0d l=%0b",
                         i, a_out_valid, a_out_word, a_out_index, a_out_last, exp[i], i, i == 1);
            end
        end
        step();
        send_b(18'h21801);
        step();
        checks++;
        if ({b_out_valid, b_out_word, b_out_index, b_out_last} !== {1'b1, exp_b, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL fold: got v=%0b w=%o i=%0d l=%0b, want v=1 w=%o i=0 l=1",
                     b_out_valid, b_out_word, b_out_index, b_out_last, exp_b);
        end
        step();
        checks++;
        if (b_out_valid !== 1'b0 || b_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL fold_done: got v=%0b rdy=%0b, want 0 1", b_out_valid, b_req_ready);
        end
    endtask

    task automatic test_error();
        logic [11:0] exp = 12'o7410;
        send_a(18'h02800);
        checks++;
        if (a_err !== 1'b1 || a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL err_pulse: got err=%0b v=%0b, want 1 0", a_err, a_out_valid);
        end
        step();
        checks++;
        if (a_err !== 1'b0 || a_out_valid !== 1'b0 || a_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL err_end: got err=%0b v=%0b rdy=%0b, want 0 0 1", a_err, a_out_valid, a_req_ready);
        end
        send_a(18'h10000);
        step();
        checks++;
        if ({a_out_valid, a_out_word, a_out_index, a_out_last, a_err} !== {1'b1, exp, 3'd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL skp_after_err: got v=%0b w=%o i=%0d l=%0b e=%0b, want v=1 w=%o i=0 l=1 e=0",
                     a_out_valid, a_out_word, a_out_index, a_out_last, a_err, exp);
        end
        step();
    endtask

    task automatic test_empty();
        logic [11:0] exp = 12'o7000;
        send_a(18'h00000);
        step();
        checks++;
        if ({a_out_valid, a_out_word, a_out_index, a_out_last} !== {1'b1, exp, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL empty_nop: got v=%0b w=%o i=%0d l=%0b, want v=1 w=%o i=0 l=1",
                     a_out_valid, a_out_word, a_out_index, a_out_last, exp);
        end
        step();
        send_b(18'h00000);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (b_out_valid !== 1'b0 || b_err !== 1'b0) begin
                errors++;
                $display("FAIL empty_silent[%0d]: got v=%0b err=%0b, want 0 0", i, b_out_valid, b_err);
            end
            step();
        end
        checks++;
        if (b_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL empty_idle: got rdy=%0b, want 1", b_req_ready);
        end
    endtask

    task automatic test_rotates_stall();
        logic [11:0] exp [6] = '{12'o7010, 12'o7004, 12'o7012, 12'o7006, 12'o7002, 12'o7450};
        out_ready = 1'b1;
        send_a(18'h043E0);
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if ({a_out_valid, a_out_word, a_out_index, a_out_last} !== {1'b1, exp[i], 3'(i), 1'(i == 5)}) begin
                errors++;
                $display("FAIL rot[%0d]: got v=%0b w=%o i=%0d l=%0b, want w=%o i=%0d l=%0b",
                         i, a_out_valid, a_out_word, a_out_index, a_out_last, exp[i], i, i == 5);
            end
            if (i == 2) begin
                out_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    step();
                    checks++;
                    if ({a_out_valid, a_out_word, a_out_index, a_out_last} !== {1'b1, exp[2], 3'd2, 1'b0}) begin
                        errors++;
                        $display("FAIL rot_hold[%0d]: got v=%0b w=%o i=%0d l=%0b, want w=%o i=2 l=0",
                                 k, a_out_valid, a_out_word, a_out_index, a_out_last, exp[2]);
                    end
                end
                out_ready = 1'b1;
            end
        end
        step();
        checks++;
        if (a_out_valid !== 1'b0 || a_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL rot_done: got v=%0b rdy=%0b, want 0 1", a_out_valid, a_req_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic [11:0] exp = 12'o7001;
        out_ready = 1'b1;
        send_a(18'h043E0);
        for (int i = 0; i < 5; i++) step();
        checks++;
        if ({a_out_valid, a_out_word, a_out_index} !== {1'b1, 12'o7002, 3'd4}) begin
            errors++;
            $display("FAIL mid_pre: got v=%0b w=%o i=%0d, want v=1 w=7002 i=4", a_out_valid, a_out_word, a_out_index);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if ({a_req_ready, a_out_valid, a_out_word, a_out_index, a_out_last, a_err} !== 19'd0) begin
            errors++;
            $display("FAIL mid_reset: got rdy=%0b v=%0b w=%o i=%0d l=%0b e=%0b, want all 0",
                     a_req_ready, a_out_valid, a_out_word, a_out_index, a_out_last, a_err);
        end
        rst_n = 1'b1;
        #1;
        send_a(18'h00010);
        step();
        checks++;
        if ({a_out_valid, a_out_word, a_out_index, a_out_last} !== {1'b1, exp, 3'd0, 1'b1}) begin
            errors++;
            $display("FAIL mid_iac: got v=%0b w=%o i=%0d l=%0b, want v=1 w=%o i=0 l=1",
                     a_out_valid, a_out_word, a_out_index, a_out_last, exp);
        end
        step();
        checks++;
        if (a_out_valid !== 1'b0 || a_req_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_done: got v=%0b rdy=%0b, want 0 1", a_out_valid, a_req_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_words();
        test_fold();
        test_error();
        test_empty();
        test_rotates_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
